aes32_dsp_cmac_msg_pad: RTL and testbench

Message-input stage of the 32-bit DSP AES-CMAC datapath. It accepts the message as a stream of 32-bit big-endian words and assembles 128-bit blocks. On the final block it applies CMAC 10* padding and the K1/K2 subkey XOR. It then presents each block as four column words, tagged with the 2-bit column index used by the CMAC feedback/column-select stage, for XOR with the chaining value.

---
 rtl/aes32_dsp_cmac_msg_pad.sv | 214 +++++++++++++++++++++
 tb/tb_aes32_dsp_cmac_msg_pad.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes32_dsp_cmac_msg_pad.sv
// CMAC message input stage: packs 32-bit big-endian words into 128-bit blocks, applies 10* padding
// and the K1/K2 subkey on the final block. Define AES32_CMAC_PING_PONG_EN for the two-buffer build.
module aes32_dsp_cmac_msg_pad (
    input  logic         CLK,
    input  logic         RST,
    input  logic [127:0] K1,
    input  logic [127:0] K2,
    input  logic [31:0]  MSG_DIN,
    input  logic [2:0]   MSG_NBYTES,
    input  logic         MSG_LAST,
    input  logic         MSG_VALID,
    output logic         MSG_READY,
    output logic [31:0]  BLK_DOUT,
    output logic [1:0]   BLK_CTRL,
    output logic         BLK_LAST,
    output logic         BLK_VALID,
    input  logic         BLK_READY
);

`ifdef AES32_CMAC_PING_PONG_EN
    localparam logic DUAL = 1'b1;
`else
    localparam logic DUAL = 1'b0;
`endif

    typedef enum logic [0:0] {ST_FILL, ST_PAD} fill_state_e;

    fill_state_e state_q, state_d;
    logic [1:0]  wc_q, wc_d;
    logic        mark_q, mark_d;
    logic        msg_start_q, msg_start_d;
    logic        wr_sel_q, wr_sel_d;
    logic        rd_sel_q, rd_sel_d;
    logic [31:0] blk_buf_q [2][4];
    logic [31:0] blk_buf_d [2][4];
    logic [1:0]  full_q, full_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  pad_q, pad_d;
    logic [1:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [31:0] dout_q, dout_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        blast_q, blast_d;

    logic        accept;
    logic        complete;
    logic [2:0]  n_eff;
    logic [31:0] word_in;
    logic        start_sel;
    logic        do_start;
    logic [1:0]  nxt_idx;

    function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] i);
        case (i)
            2'd0:    key_word = k[127:96];
            2'd1:    key_word = k[95:64];
            2'd2:    key_word = k[63:32];
            default: key_word = k[31:0];
        endcase
    endfunction

    function automatic logic [31:0] out_word(input logic [31:0] w, input logic fin, input logic pd,
                                             input logic [127:0] k1, input logic [127:0] k2,
                                             input logic [1:0] i);
        if (fin) out_word = w ^ key_word(pd ? k2 : k1, i);
        else     out_word = w;
    endfunction

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        mark_d      = mark_q;
        msg_start_d = msg_start_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        blk_buf_d   = blk_buf_q;
        full_d      = full_q;
        last_d      = last_q;
        pad_d       = pad_q;
        idx_d       = idx_q;
        valid_d     = valid_q;
        dout_d      = dout_q;
        ctrl_d      = ctrl_q;
        blast_d     = blast_q;
        complete    = 1'b0;
        do_start    = 1'b0;
        start_sel   = rd_sel_q;
        nxt_idx     = idx_q + 2'd1;

        MSG_READY = !RST && (state_q == ST_FILL) && !full_q[wr_sel_q];
        accept    = MSG_READY && MSG_VALID;

        // NBYTES=0 means "empty" only on the first word of a message; everywhere else it is a full word
        if (!MSG_LAST || (MSG_NBYTES > 3'd4) || ((MSG_NBYTES == 3'd0) && !msg_start_q))
            n_eff = 3'd4;
        else
            n_eff = MSG_NBYTES;

        case (n_eff)
            3'd0:    word_in = 32'h8000_0000;
            3'd1:    word_in = {MSG_DIN[31:24], 24'h80_0000};
            3'd2:    word_in = {MSG_DIN[31:16], 16'h8000};
            3'd3:    word_in = {MSG_DIN[31:8], 8'h80};
            default: word_in = MSG_DIN;
        endcase

        if (accept) begin
            blk_buf_d[wr_sel_q][wc_q] = word_in;
            msg_start_d = MSG_LAST;
            if (!MSG_LAST) begin
                if (wc_q == 2'd3) begin
                    complete         = 1'b1;
                    last_d[wr_sel_q] = 1'b0;
                    pad_d[wr_sel_q]  = 1'b0;
                end else begin
                    wc_d = wc_q + 2'd1;
                end
            end else begin
                last_d[wr_sel_q] = 1'b1;
                pad_d[wr_sel_q]  = (n_eff != 3'd4) || (wc_q != 2'd3);
                if (wc_q == 2'd3) begin
                    complete = 1'b1;
                end else begin
                    state_d = ST_PAD;
                    wc_d    = wc_q + 2'd1;
                    mark_d  = (n_eff == 3'd4);
                end
            end
        end else if (state_q == ST_PAD) begin
            blk_buf_d[wr_sel_q][wc_q] = mark_q ? 32'h8000_0000 : '0;
            mark_d = 1'b0;
            if (wc_q == 2'd3) complete = 1'b1;
            else              wc_d = wc_q + 2'd1;
        end

        if (complete) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = wr_sel_q ^ DUAL;
            wc_d             = '0;
            state_d          = ST_FILL;
        end

        // A buffer completing this cycle may start draining at once, hence the *_d reads below
        if (valid_q && BLK_READY) begin
            if (idx_q != 2'd3) begin
                idx_d  = nxt_idx;
                ctrl_d = nxt_idx;
                dout_d = out_word(blk_buf_d[rd_sel_q][nxt_idx], last_d[rd_sel_q], pad_d[rd_sel_q],
                                  K1, K2, nxt_idx);
            end else begin
                full_d[rd_sel_q] = 1'b0;
                valid_d          = 1'b0;
                start_sel        = rd_sel_q ^ DUAL;
                rd_sel_d         = start_sel;
                do_start         = full_d[start_sel];
            end
        end else if (!valid_q) begin
            do_start = full_d[rd_sel_q];
        end

        if (do_start) begin
            valid_d = 1'b1;
            idx_d   = '0;
            ctrl_d  = '0;
            blast_d = last_d[start_sel];
            dout_d  = out_word(blk_buf_d[start_sel][0], last_d[start_sel], pad_d[start_sel],
                               K1, K2, 2'd0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_FILL;
            wc_q        <= '0;
            mark_q      <= 1'b0;
            msg_start_q <= 1'b1;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            full_q      <= '0;
            last_q      <= '0;
            pad_q       <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            dout_q      <= '0;
            ctrl_q      <= '0;
            blast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            mark_q      <= mark_d;
            msg_start_q <= msg_start_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            full_q      <= full_d;
            last_q      <= last_d;
            pad_q       <= pad_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            ctrl_q      <= ctrl_d;
            blast_q     <= blast_d;
        end
    end

    always_ff @(posedge CLK) begin
        blk_buf_q <= blk_buf_d;
    end

    assign BLK_DOUT  = dout_q;
    assign BLK_CTRL  = ctrl_q;
    assign BLK_LAST  = blast_q;
    assign BLK_VALID = valid_q;

endmodule

// File: tb/tb_aes32_dsp_cmac_msg_pad.sv
// Scoreboard bench for aes32_dsp_cmac_msg_pad: a byte-level CMAC padding model pushes expected
// block words; a negedge monitor compares every valid output (including stalled cycles).
module tb_aes32_dsp_cmac_msg_pad;

`ifdef AES32_CMAC_PING_PONG_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [127:0] K1 = 128'hFBEED618_35713366_7C85E08F_7236A8DE;
    logic [127:0] K2 = 128'hF7DDAC30_6AE266CC_F90BC11E_E46D513B;
    logic [31:0]  MSG_DIN = '0;
    logic [2:0]   MSG_NBYTES = '0;
    logic         MSG_LAST = 1'b0;
    logic         MSG_VALID = 1'b0;
    logic         MSG_READY;
    logic [31:0]  BLK_DOUT;
    logic [1:0]   BLK_CTRL;
    logic         BLK_LAST;
    logic         BLK_VALID;
    logic         BLK_READY = 1'b0;

    aes32_dsp_cmac_msg_pad dut (
        .CLK        (CLK),
        .RST        (RST),
        .K1         (K1),
        .K2         (K2),
        .MSG_DIN    (MSG_DIN),
        .MSG_NBYTES (MSG_NBYTES),
        .MSG_LAST   (MSG_LAST),
        .MSG_VALID  (MSG_VALID),
        .MSG_READY  (MSG_READY),
        .BLK_DOUT   (BLK_DOUT),
        .BLK_CTRL   (BLK_CTRL),
        .BLK_LAST   (BLK_LAST),
        .BLK_VALID  (BLK_VALID),
        .BLK_READY  (BLK_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  c;
        logic        l;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] msg[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_acc_cyc = 0;
    int last_pop_cyc = 0;
    int low_cnt = 0;
    int rdy_mode = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // output-side backpressure
    initial begin
        int ph = 0;
        forever begin
            @(posedge CLK);
            #1;
            case (rdy_mode)
                0:       BLK_READY = 1'b1;
                1:       BLK_READY = ((ph % 4) == 0) || ((ph % 4) == 3);
                2:       BLK_READY = 1'b0;
                default: BLK_READY = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // monitor
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && BLK_VALID) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(BLK_VALID), 64'd0);
                end else begin
                    chk("dout", 64'(BLK_DOUT), 64'(sb[0].d));
                    chk("ctrl", 64'(BLK_CTRL), 64'(sb[0].c));
                    chk("last", 64'(BLK_LAST), 64'(sb[0].l));
                    if (BLK_READY) begin
                        void'(sb.pop_front());
                        last_pop_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_expected();
        int          len;
        int          nblk;
        int          idx;
        logic [31:0] w;
        logic [7:0]  b;
        logic [127:0] k;
        exp_t        e;
        logic        fin;
        len  = msg.size();
        nblk = (len == 0) ? 1 : (len + 15) / 16;
        k    = ((len != 0) && ((len % 16) == 0)) ? K1 : K2;
        for (int bi = 0; bi < nblk; bi++) begin
            fin = (bi == nblk - 1);
            for (int wi = 0; wi < 4; wi++) begin
                w = '0;
                for (int j = 0; j < 4; j++) begin
                    idx = bi * 16 + wi * 4 + j;
                    if (idx < len)       b = msg[idx];
                    else if (idx == len) b = 8'h80;
                    else                 b = 8'h00;
                    w = {w[23:0], b};
                end
                if (fin) w = w ^ k[127 - 32 * wi -: 32];
                e.d = w;
                e.c = 2'(wi);
                e.l = fin;
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic l);
        int w = 0;
        MSG_DIN    = d;
        MSG_NBYTES = n;
        MSG_LAST   = l;
        MSG_VALID  = 1'b1;
        @(negedge CLK);
        while (!MSG_READY && (w < 200)) begin
            low_cnt++;
            w++;
            @(negedge CLK);
        end
        if (!MSG_READY) chk("ready_timeout", 64'(MSG_READY), 64'd1);
        acc_cyc = cyc;
        @(posedge CLK);
        #1;
        MSG_VALID = 1'b0;
    endtask

    task automatic send_msg();
        int          len;
        int          nw;
        int          nb;
        int          idx;
        logic        l;
        logic [31:0] d;
        len = msg.size();
        push_expected();
        nw = (len == 0) ? 1 : (len + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * w + j;
                d = {d[23:0], (idx < len) ? msg[idx] : 8'hA5};
            end
            l = (w == nw - 1);
            if (!l)            nb = $urandom_range(0, 3);
            else if (len == 0) nb = 0;
            else               nb = len - 4 * w;
            send_word(d, 3'(nb), l);
            if (w == 0) first_acc_cyc = acc_cyc;
        end
    endtask

    task automatic check_latency(input string tag, input int exp);
        int c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (!BLK_VALID && (c < 50));
        chk(tag, 64'(c), 64'(exp));
    endtask

    task automatic wait_drain();
        int c = 0;
        while (((sb.size() != 0) || BLK_VALID) && (c < 3000)) begin
            @(negedge CLK);
            c++;
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic set_msg(input int len, input int mode);
        msg.delete();
        for (int i = 0; i < len; i++) begin
            case (mode)
                0:       msg.push_back(8'(i * 17));
                1:       msg.push_back(8'(i + 1));
                default: msg.push_back(8'($urandom_range(0, 255)));
            endcase
        end
    endtask

    initial begin
        int lens[16] = '{1, 2, 3, 4, 8, 12, 15, 16, 17, 20, 31, 32, 33, 47, 48, 64};

        // reset with a pending word on the input
        RST        = 1'b1;
        MSG_VALID  = 1'b1;
        MSG_LAST   = 1'b1;
        MSG_NBYTES = 3'd4;
        MSG_DIN    = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_valid", 64'(BLK_VALID), 64'd0);
            chk("rst_dout", 64'(BLK_DOUT), 64'd0);
            chk("rst_ctrl", 64'(BLK_CTRL), 64'd0);
            chk("rst_last", 64'(BLK_LAST), 64'd0);
            chk("rst_ready", 64'(MSG_READY), 64'd0);
        end
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        MSG_VALID = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", 64'(MSG_READY), 64'd1);
        @(posedge CLK);
        #1;

        // empty message: 3 pad cycles
        set_msg(0, 0);
        send_msg();
        check_latency("lat_empty", 4);
        wait_drain();

        // 16-byte message: complete final block, K1
        set_msg(16, 0);
        send_msg();
        check_latency("lat_16", 1);
        wait_drain();

        // 5-byte message: 2 pad cycles, K2
        set_msg(5, 1);
        send_msg();
        check_latency("lat_5", 3);
        wait_drain();

        // 15 bytes: short last word at column 3, no pad cycles
        set_msg(15, 2);
        send_msg();
        check_latency("lat_15", 1);
        wait_drain();

        // 12 bytes: full word at column 2, pad word carries the 0x80 marker
        set_msg(12, 2);
        send_msg();
        check_latency("lat_12", 2);
        wait_drain();

        // 32 bytes with stalled output
        rdy_mode = 1;
        set_msg(32, 0);
        send_msg();
        wait_drain();
        rdy_mode = 0;
        @(posedge CLK);
        #1;

        // 8 back-to-back words
        low_cnt = 0;
        set_msg(32, 2);
        send_msg();
        wait_drain();
        chk("ready_low_cycles", 64'(low_cnt), DUAL ? 64'd0 : 64'd4);
        chk("burst_elapsed", 64'(last_pop_cyc - first_acc_cyc), DUAL ? 64'd11 : 64'd15);

        // reset mid-message: partial block discarded, word counter restarts
        send_word(32'h1111_1111, 3'd4, 1'b0);
        send_word(32'h2222_2222, 3'd4, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_valid", 64'(BLK_VALID), 64'd0);
        chk("rst_mid_ready", 64'(MSG_READY), 64'd1);
        repeat (10) @(negedge CLK);
        @(posedge CLK);
        #1;
        set_msg(5, 1);
        send_msg();
        check_latency("lat_after_rst", 3);
        wait_drain();

        // reset mid-drain while stalled
        rdy_mode = 2;
        repeat (2) @(posedge CLK);
        #1;
        set_msg(16, 2);
        send_msg();
        check_latency("lat_stall", 1);
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        sb.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_drain_valid", 64'(BLK_VALID), 64'd0);
        chk("rst_drain_dout", 64'(BLK_DOUT), 64'd0);
        rdy_mode = 0;
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #1;

        // back-to-back messages with random backpressure
        rdy_mode = 3;
        foreach (lens[i]) begin
            set_msg(lens[i], 2);
            send_msg();
        end
        wait_drain();
        rdy_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
